// File: rtl/display_scanout_pkg.sv
// Shared VGA timing constants and framebuffer address layout, used by the
// scanout and by the renderer that fills the framebuffer.
package display_scanout_pkg;

   localparam int VGA_H_VIS  = 640;
   localparam int VGA_H_FP   = 16;
   localparam int VGA_H_SYNC = 96;
   localparam int VGA_H_BP   = 48;
   localparam int VGA_V_VIS  = 480;
   localparam int VGA_V_FP   = 10;
   localparam int VGA_V_SYNC = 2;
   localparam int VGA_V_BP   = 33;
   localparam int VGA_X_OFS  = 64;
   localparam int VGA_Y_OFS  = 112;

   localparam int IMG_W = 512;
   localparam int IMG_H = 256;
   localparam int FB_AW = 10;

   // One framebuffer row is 8 bytes on a 32-byte stride; each bit is an 8x8 block.
   function automatic logic [FB_AW-1:0] fb_addr(input logic [4:0] blk_row,
                                                 input logic [2:0] blk_byte);
      return {blk_row, 2'b00, blk_byte};
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters and raw (undelayed) active-low syncs.
// The *_nxt outputs are the values the counters take at the next clk edge.
module vga_timing
   import display_scanout_pkg::*;
#(
   parameter int H_VIS  = VGA_H_VIS,
   parameter int H_FP   = VGA_H_FP,
   parameter int H_SYNC = VGA_H_SYNC,
   parameter int H_BP   = VGA_H_BP,
   parameter int V_VIS  = VGA_V_VIS,
   parameter int V_FP   = VGA_V_FP,
   parameter int V_SYNC = VGA_V_SYNC,
   parameter int V_BP   = VGA_V_BP
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] hcnt_nxt,
   output logic [9:0] vcnt_nxt,
   output logic       hsync_raw,
   output logic       vsync_raw
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);

   logic [9:0] hcnt;
   logic [9:0] vcnt;

   always_comb begin
      hcnt_nxt = hcnt + 10'd1;
      vcnt_nxt = vcnt;
      if (hcnt == H_LAST) begin
         hcnt_nxt = '0;
         vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
      end
   end

   // Syncs are decoded from the next count so they stay aligned with hcnt/vcnt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcnt      <= '0;
         vcnt      <= '0;
         hsync_raw <= 1'b1;
         vsync_raw <= 1'b1;
      end else begin
         hcnt      <= hcnt_nxt;
         vcnt      <= vcnt_nxt;
         hsync_raw <= ~((hcnt_nxt >= HS_BEG) && (hcnt_nxt <= HS_END));
         vsync_raw <= ~((vcnt_nxt >= VS_BEG) && (vcnt_nxt <= VS_END));
      end
   end

endmodule

// File: rtl/display_scanout.sv
// Monochrome 512x256 framebuffer scanout: fetches one byte per 64 pixels and
// shows every bit as an 8x8 block, with pixel and syncs aligned at the pins.
module display_scanout
   import display_scanout_pkg::*;
#(
   parameter int H_VIS  = VGA_H_VIS,
   parameter int H_FP   = VGA_H_FP,
   parameter int H_SYNC = VGA_H_SYNC,
   parameter int H_BP   = VGA_H_BP,
   parameter int V_VIS  = VGA_V_VIS,
   parameter int V_FP   = VGA_V_FP,
   parameter int V_SYNC = VGA_V_SYNC,
   parameter int V_BP   = VGA_V_BP,
   parameter int X_OFS  = VGA_X_OFS,
   parameter int Y_OFS  = VGA_Y_OFS
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] fb_read_address,
   input  logic [7:0] fb_ram_out,
   output logic       vga_hsync,
   output logic       vga_vsync,
   output logic       vga_pixel,
   output logic       vblank,
   output logic       frame_start
);

   // The image is clipped to the visible area so nothing lights during blanking.
   localparam int X_LIM = (X_OFS + IMG_W < H_VIS) ? X_OFS + IMG_W : H_VIS;
   localparam int Y_LIM = (Y_OFS + IMG_H < V_VIS) ? Y_OFS + IMG_H : V_VIS;

   localparam logic [9:0] X_BEG = 10'(X_OFS);
   localparam logic [9:0] X_END = 10'(X_LIM);
   localparam logic [9:0] Y_BEG = 10'(Y_OFS);
   localparam logic [9:0] Y_END = 10'(Y_LIM);
   localparam logic [9:0] V_BLK = 10'(V_VIS);

   logic [9:0] hcnt_nxt;
   logic [9:0] vcnt_nxt;
   logic       hsync_raw;
   logic       vsync_raw;
   logic       img_act;
   logic [5:0] dx_blk;
   logic [4:0] dy_blk;

   logic       vld_p0;
   logic [2:0] bsel_p0;
   logic       vld_p1;
   logic [2:0] bsel_p1;
   logic       hs_p1;
   logic       vs_p1;

   vga_timing #(
      .H_VIS (H_VIS),
      .H_FP  (H_FP),
      .H_SYNC(H_SYNC),
      .H_BP  (H_BP),
      .V_VIS (V_VIS),
      .V_FP  (V_FP),
      .V_SYNC(V_SYNC),
      .V_BP  (V_BP)
   ) u_timing (
      .clk      (clk),
      .reset    (reset),
      .hcnt_nxt (hcnt_nxt),
      .vcnt_nxt (vcnt_nxt),
      .hsync_raw(hsync_raw),
      .vsync_raw(vsync_raw)
   );

   assign img_act = (hcnt_nxt >= X_BEG) && (hcnt_nxt < X_END) &&
                    (vcnt_nxt >= Y_BEG) && (vcnt_nxt < Y_END);
   assign dx_blk  = 6'((hcnt_nxt - X_BEG) >> 3);
   assign dy_blk  = 5'((vcnt_nxt - Y_BEG) >> 3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fb_read_address <= '0;
         vld_p0          <= 1'b0;
         bsel_p0         <= '0;
         vld_p1          <= 1'b0;
         bsel_p1         <= '0;
         hs_p1           <= 1'b1;
         vs_p1           <= 1'b1;
         vga_pixel       <= 1'b0;
         vga_hsync       <= 1'b1;
         vga_vsync       <= 1'b1;
         vblank          <= 1'b0;
         frame_start     <= 1'b0;
      end else begin
         // stage 0: address and bit select for the pixel now on the counters
         if (img_act)
            fb_read_address <= fb_addr(dy_blk, dx_blk[5:3]);
         vld_p0  <= img_act;
         bsel_p0 <= dx_blk[2:0];
         // stage 1: the RAM returns the stage-0 byte during this cycle
         vld_p1  <= vld_p0;
         bsel_p1 <= bsel_p0;
         hs_p1   <= hsync_raw;
         vs_p1   <= vsync_raw;
         // stage 2: pins, bit 7 of the byte is the leftmost block
         vga_pixel <= vld_p1 & fb_ram_out[3'd7 - bsel_p1];
         vga_hsync <= hs_p1;
         vga_vsync <= vs_p1;
         vblank      <= (vcnt_nxt >= V_BLK);
         frame_start <= (vcnt_nxt == V_BLK) && (hcnt_nxt == '0);
      end
   end

endmodule

// File: doc/display_scanout.md
DISPLAY_SCANOUT -- requirements
Module: display_scanout

Interface
REQ-001 Parameter H_VIS, 640, visible pixels per line.
REQ-002 Parameter H_FP/H_SYNC/H_BP, 16/96/48, horizontal porch and sync widths; H_TOTAL = 800.
REQ-003 Parameter V_VIS, 480, visible lines per frame.
REQ-004 Parameter V_FP/V_SYNC/V_BP, 10/2/33, vertical porch and sync widths; V_TOTAL = 525.
REQ-005 Parameter X_OFS/Y_OFS, 64/112, top-left corner of the 512x256 image inside the visible area.
REQ-006 clk  in  1  pixel clock, 25.175 MHz nominal; single clock domain; all logic on posedge clk.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 fb_read_address  out  10  framebuffer RAM read address.
REQ-009 fb_ram_out  in  8  framebuffer RAM read data, valid exactly one clk after the address.
REQ-010 vga_hsync  out  1  horizontal sync, active-low.
REQ-011 vga_vsync  out  1  vertical sync, active-low.
REQ-012 vga_pixel  out  1  monochrome pixel, 1 = lit; 0 outside the image and during blanking.
REQ-013 vblank  out  1  high while the vertical counter is at or above V_VIS.
REQ-014 frame_start  out  1  one-clk pulse on the first clk of vblank; drives the renderer start_signal.

Function
REQ-015 hcnt SHALL count 0..H_TOTAL-1 and wrap to 0; vcnt SHALL increment when hcnt wraps and wrap to 0 after V_TOTAL-1.
REQ-016 Raw hsync SHALL be low for hcnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656,751]; raw vsync SHALL be low for vcnt in [490,491].
REQ-017 The image region SHALL be hcnt in [X_OFS, X_OFS+511] and vcnt in [Y_OFS, Y_OFS+255]; each framebuffer pixel SHALL be shown as an 8x8 block.
REQ-018 With dx = hcnt-X_OFS and dy = vcnt-Y_OFS, the address SHALL be {dy[7:3], 2'b00, dx[8:6]}: row stride 32 bytes, 8 bytes per row.
REQ-019 The bit within a byte SHALL be selected by dx[5:3], with bit 7 leftmost (MSB first).
REQ-020 Pipeline: stage 0 registers fb_read_address; stage 1 receives fb_ram_out; stage 2 registers vga_pixel. Total latency from counter to pins SHALL be 2 clk.
REQ-021 hsync, vsync, image-active and bit-select SHALL be delayed by 2 clk so pixel and sync stay aligned at the pins.
REQ-022 Outside the image region, fb_read_address SHALL hold its last value and vga_pixel SHALL be 0.
REQ-023 vblank and frame_start SHALL be derived from undelayed vcnt and registered. frame_start SHALL be asserted for exactly one clk per frame, at vcnt = V_VIS and hcnt = 0.
REQ-024 fb RAM read data SHALL be sampled only in its valid cycle and SHALL NOT be buffered beyond one byte.

Reset
REQ-025 While reset is high: hcnt = vcnt = 0, fb_read_address = 0, vga_hsync = vga_vsync = 1, vga_pixel = 0, vblank = 0, frame_start = 0, and all pipeline stages cleared.
REQ-026 After reset is released mid-frame, scanning SHALL restart at hcnt = vcnt = 0. The first hsync low SHALL occur 656+2 clk after the first clk edge following deassertion.

Structure
REQ-027 The timing constants (H_/V_ values, X_OFS, Y_OFS) and the 10-bit address layout helper SHALL live in a shared package/include, also used by the renderer.
REQ-028 The counters and raw sync generation SHALL be one sub-module, vga_timing. The address, bit-select and pixel pipeline SHALL remain in display_scanout.

Verification
REQ-029 Free-run 2 frames after reset -> hsync period 800 clk with 96 clk low; vsync period 420000 clk with 1600 clk low; frame_start pulses exactly 2 times, 420000 clk apart.
REQ-030 fb model filled with address[7:0]; at hcnt = 64+128, vcnt = 112+16 -> fb_read_address = 0x042 (row 2, byte 2).
REQ-031 Byte 0x80 at address 0x000, others 0 -> vga_pixel high exactly for hcnt 66..73 on pins (2-clk latency), vcnt 112..119, low elsewhere.
REQ-032 All bytes 0xFF -> vga_pixel high exactly in hcnt 66..577 (pin timing) on lines 112..367, never during sync or blanking.
REQ-033 Assert reset at vcnt = 300, hcnt = 400, for 3 clk -> outputs hold reset values; after release, hcnt restarts at 0, and no frame_start occurs before vcnt reaches 480.
REQ-034 1-clk RAM latency model vs 0-latency model -> pixel pattern shifted by one column in the 0-latency case, confirming the pipeline alignment check catches a latency mismatch.
